// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Configuration, pixel-fetch and video-output bundle for
//                vga_timing_gen.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW = 4,
    parameter int HW = 12,
    parameter int VW = 11
);
    logic            enable_i;
    logic [HW-1:0]   h_total_i;
    logic [HW-1:0]   h_sync_i;
    logic [HW-1:0]   h_act_beg_i;
    logic [HW-1:0]   h_act_end_i;
    logic [VW-1:0]   v_total_i;
    logic [VW-1:0]   v_sync_i;
    logic [VW-1:0]   v_act_beg_i;
    logic [VW-1:0]   v_act_end_i;
    logic            hpol_i;
    logic            vpol_i;
    logic [1:0]      mode_i;
    logic [3*CW-1:0] solid_i;
    logic [3*CW-1:0] data_i;
    logic            data_req_o;
    logic [3*CW-1:0] rgb_o;
    logic            de_o;
    logic            hsync_o;
    logic            vsync_o;
    logic            frame_o;

    modport master (
        output enable_i, h_total_i, h_sync_i, h_act_beg_i, h_act_end_i,
               v_total_i, v_sync_i, v_act_beg_i, v_act_end_i,
               hpol_i, vpol_i, mode_i, solid_i, data_i,
        input  data_req_o, rgb_o, de_o, hsync_o, vsync_o, frame_o
    );

    modport slave (
        input  enable_i, h_total_i, h_sync_i, h_act_beg_i, h_act_end_i,
               v_total_i, v_sync_i, v_act_beg_i, v_act_end_i,
               hpol_i, vpol_i, mode_i, solid_i, data_i,
        output data_req_o, rgb_o, de_o, hsync_o, vsync_o, frame_o
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Runtime-programmable VGA timing with frame-synchronous shadow
//                configuration and a two-stage pixel/test-pattern pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CW = 4,
    parameter int HW = 12,
    parameter int VW = 11
) (
    input  logic            clk,
    input  logic            reset,
    vga_timing_gen_if.slave bus
);
    localparam logic [HW-1:0] c_h_one = HW'(1);
    localparam logic [VW-1:0] c_v_one = VW'(1);

    // Shadow configuration, stable for a whole frame
    logic [HW-1:0]   r_h_total, r_h_sync, r_h_act_beg, r_h_act_end, r_bar_w;
    logic [VW-1:0]   r_v_total, r_v_sync, r_v_act_beg, r_v_act_end;
    logic            r_hpol, r_vpol;
    logic [1:0]      r_mode;
    logic [3*CW-1:0] r_solid;

    logic [HW-1:0]   r_h;
    logic [VW-1:0]   r_v;

    // Stage 1
    logic            r1_req, r1_hsync, r1_vsync, r1_frame, r1_bar_zero;
    logic [HW-1:0]   r1_x, r1_bar_cnt;
    logic [VW-1:0]   r1_y;
    logic [2:0]      r1_bar_idx;
    logic [1:0]      r1_mode;
    logic [3*CW-1:0] r1_solid;

    // Stage 2
    logic [3*CW-1:0] r_rgb;
    logic            r_de, r_hsync, r_vsync, r_frame;

    logic            w_idle, w_h_wrap, w_v_wrap, w_load;
    logic            w_hs, w_vs, w_act, w_frame, w_line_start;
    logic [2:0]      w_bar_mask;
    logic [3*CW-1:0] w_pix;

    assign w_idle       = reset || !bus.enable_i;
    assign w_h_wrap     = (r_h >= r_h_total - c_h_one);
    assign w_v_wrap     = (r_v >= r_v_total - c_v_one);
    assign w_load       = w_idle || (w_h_wrap && w_v_wrap);
    assign w_hs         = (r_h < r_h_sync);
    assign w_vs         = (r_v < r_v_sync);
    assign w_act        = (r_h >= r_h_act_beg) && (r_h < r_h_act_end) &&
                          (r_v >= r_v_act_beg) && (r_v < r_v_act_end);
    assign w_frame      = (r_h == '0) && (r_v == '0);
    assign w_line_start = (r_h == r_h_act_beg);

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_h_total   <= bus.h_total_i;
            r_h_sync    <= bus.h_sync_i;
            r_h_act_beg <= bus.h_act_beg_i;
            r_h_act_end <= bus.h_act_end_i;
            r_v_total   <= bus.v_total_i;
            r_v_sync    <= bus.v_sync_i;
            r_v_act_beg <= bus.v_act_beg_i;
            r_v_act_end <= bus.v_act_end_i;
            r_hpol      <= bus.hpol_i;
            r_vpol      <= bus.vpol_i;
            r_mode      <= bus.mode_i;
            r_solid     <= bus.solid_i;
            r_bar_w     <= (bus.h_act_end_i - bus.h_act_beg_i) >> 3;
        end
    end

    // >= rather than == so a counter beyond a freshly reduced total wraps at once
    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= w_v_wrap ? '0 : r_v + c_v_one;
        end else begin
            r_h <= r_h + c_h_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_idle) begin
            r1_req      <= 1'b0;
            r1_hsync    <= ~bus.hpol_i;
            r1_vsync    <= ~bus.vpol_i;
            r1_frame    <= 1'b0;
            r1_x        <= '0;
            r1_y        <= '0;
            r1_bar_cnt  <= '0;
            r1_bar_idx  <= '0;
            r1_bar_zero <= 1'b0;
            r1_mode     <= '0;
            r1_solid    <= '0;
        end else begin
            r1_req      <= w_act;
            r1_hsync    <= r_hpol ? w_hs : ~w_hs;
            r1_vsync    <= r_vpol ? w_vs : ~w_vs;
            r1_frame    <= w_frame;
            r1_bar_zero <= (r_bar_w == '0);
            r1_mode     <= r_mode;
            r1_solid    <= r_solid;
            // x/y and bar position restart at the first active column of each line
            if (w_line_start) begin
                r1_x       <= '0;
                r1_y       <= (r_v == r_v_act_beg) ? '0 : r1_y + c_v_one;
                r1_bar_cnt <= '0;
                r1_bar_idx <= '0;
            end else begin
                r1_x <= r1_x + c_h_one;
                if (r1_bar_cnt >= r_bar_w - c_h_one) begin
                    r1_bar_cnt <= '0;
                    if (r1_bar_idx != 3'd7)
                        r1_bar_idx <= r1_bar_idx + 3'd1;
                end else begin
                    r1_bar_cnt <= r1_bar_cnt + c_h_one;
                end
            end
        end
    end

    // Bar colour as {blue,green,red} enables: R G B Y C M K W
    always_comb begin
        w_bar_mask = 3'b111;
        case (r1_bar_idx)
            3'd0: w_bar_mask = 3'b001;
            3'd1: w_bar_mask = 3'b010;
            3'd2: w_bar_mask = 3'b100;
            3'd3: w_bar_mask = 3'b011;
            3'd4: w_bar_mask = 3'b110;
            3'd5: w_bar_mask = 3'b101;
            3'd6: w_bar_mask = 3'b000;
            3'd7: w_bar_mask = 3'b111;
        endcase
    end

    always_comb begin
        w_pix = '0;
        case (r1_mode)
            2'd0: w_pix = bus.data_i;
            2'd1: begin
                if (r1_bar_zero)
                    w_pix = '1;
                else
                    w_pix = {{CW{w_bar_mask[2]}}, {CW{w_bar_mask[1]}}, {CW{w_bar_mask[0]}}};
            end
            2'd2: w_pix = {(3*CW){r1_x[4] ^ r1_y[4]}};
            2'd3: w_pix = r1_solid;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_rgb   <= '0;
            r_de    <= 1'b0;
            r_hsync <= ~bus.hpol_i;
            r_vsync <= ~bus.vpol_i;
            r_frame <= 1'b0;
        end else begin
            r_rgb   <= r1_req ? w_pix : '0;
            r_de    <= r1_req;
            r_hsync <= r1_hsync;
            r_vsync <= r1_vsync;
            r_frame <= r1_frame;
        end
    end

    assign bus.data_req_o = r1_req;
    assign bus.rgb_o      = r_rgb;
    assign bus.de_o       = r_de;
    assign bus.hsync_o    = r_hsync;
    assign bus.vsync_o    = r_vsync;
    assign bus.frame_o    = r_frame;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Randomised scoreboard bench for vga_timing_gen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;
    localparam int CW = 4;
    localparam int HW = 12;
    localparam int VW = 11;

    typedef struct {
        int htot, hsync, hb, he, vtot, vsync, vb, ve;
        logic hpol, vpol;
        int mode;
        logic [11:0] solid;
        int bw;
    } cfg_t;
    typedef struct { int due; logic [11:0] rgb; logic de, hs, vs, fr; } exp_t;
    typedef struct { int due; logic req; } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q_out[$];
    req_t q_req[$];
    int mh, mv;
    cfg_t sh;
    logic [11:0] d_now, d_next;

    vga_timing_gen_if #(.CW(CW), .HW(HW), .VW(VW)) bus ();
    vga_timing_gen #(.CW(CW), .HW(HW), .VW(VW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic cfg_t read_inputs();
        cfg_t c;
        c.htot  = int'(bus.h_total_i);
        c.hsync = int'(bus.h_sync_i);
        c.hb    = int'(bus.h_act_beg_i);
        c.he    = int'(bus.h_act_end_i);
        c.vtot  = int'(bus.v_total_i);
        c.vsync = int'(bus.v_sync_i);
        c.vb    = int'(bus.v_act_beg_i);
        c.ve    = int'(bus.v_act_end_i);
        c.hpol  = bus.hpol_i;
        c.vpol  = bus.vpol_i;
        c.mode  = int'(bus.mode_i);
        c.solid = bus.solid_i;
        c.bw    = ((c.he - c.hb) & 32'hFFF) >> 3;
        return c;
    endfunction

    function automatic logic [11:0] colour(cfg_t c, int x, int y, logic [11:0] d);
        logic [11:0] bars [8];
        int idx;
        bars = '{12'h00F, 12'h0F0, 12'hF00, 12'h0FF, 12'hFF0, 12'hF0F, 12'h000, 12'hFFF};
        case (c.mode)
            0: return d;
            1: begin
                if (c.bw == 0) return 12'hFFF;
                idx = x / c.bw;
                if (idx > 7) idx = 7;
                return bars[idx];
            end
            2: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: return c.solid;
        endcase
    endfunction

    // Predicts the outputs for the pixel at the current model position
    task automatic model_step();
        int k;
        exp_t e;
        req_t r;
        logic hsf, vsf, act;
        k = cyc;
        bus.data_i = d_now;
        d_next = 12'($urandom);
        if (reset || !bus.enable_i) begin
            while (q_out.size() > 0 && q_out[$].due > k) void'(q_out.pop_back());
            while (q_req.size() > 0 && q_req[$].due > k) void'(q_req.pop_back());
            e.rgb = '0; e.de = 1'b0; e.fr = 1'b0;
            e.hs = ~bus.hpol_i; e.vs = ~bus.vpol_i;
            e.due = k + 1; q_out.push_back(e);
            e.due = k + 2; q_out.push_back(e);
            r.due = k + 1; r.req = 1'b0; q_req.push_back(r);
            mh = 0; mv = 0;
            sh = read_inputs();
        end else begin
            hsf = (mh < sh.hsync);
            vsf = (mv < sh.vsync);
            act = (mh >= sh.hb) && (mh < sh.he) && (mv >= sh.vb) && (mv < sh.ve);
            e.due = k + 2;
            e.de  = act;
            e.hs  = sh.hpol ? hsf : ~hsf;
            e.vs  = sh.vpol ? vsf : ~vsf;
            e.fr  = (mh == 0) && (mv == 0);
            e.rgb = act ? colour(sh, mh - sh.hb, mv - sh.vb, d_next) : 12'h000;
            q_out.push_back(e);
            r.due = k + 1; r.req = act; q_req.push_back(r);
            if (mh >= sh.htot - 1) begin
                mh = 0;
                if (mv >= sh.vtot - 1) begin
                    mv = 0;
                    sh = read_inputs();
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
        d_now = d_next;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        req_t r;
        while (q_out.size() > 0 && q_out[0].due <= cyc) begin
            e = q_out.pop_front();
            if (e.due == cyc) begin
                checks++;
                if ({bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o, bus.frame_o} !==
                    {e.rgb, e.de, e.hs, e.vs, e.fr}) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d got rgb=%h de=%b hs=%b vs=%b fr=%b want rgb=%h de=%b hs=%b vs=%b fr=%b",
                             cyc, bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o, bus.frame_o,
                             e.rgb, e.de, e.hs, e.vs, e.fr);
                end
            end
        end
        while (q_req.size() > 0 && q_req[0].due <= cyc) begin
            r = q_req.pop_front();
            if (r.due == cyc) begin
                checks++;
                if (bus.data_req_o !== r.req) begin
                    errors++;
                    $display("FAIL data_req cyc=%0d got %b want %b", cyc, bus.data_req_o, r.req);
                end
            end
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(int ht, int hs, int hb, int he, int vt, int vs, int vb, int ve,
                           logic hp, logic vp, int mode, logic [11:0] solid);
        bus.h_total_i   = HW'(ht);
        bus.h_sync_i    = HW'(hs);
        bus.h_act_beg_i = HW'(hb);
        bus.h_act_end_i = HW'(he);
        bus.v_total_i   = VW'(vt);
        bus.v_sync_i    = VW'(vs);
        bus.v_act_beg_i = VW'(vb);
        bus.v_act_end_i = VW'(ve);
        bus.hpol_i      = hp;
        bus.vpol_i      = vp;
        bus.mode_i      = 2'(mode);
        bus.solid_i     = solid;
    endtask

    task automatic rand_cfg();
        int ht, vt;
        ht = $urandom_range(4, 60);
        vt = $urandom_range(2, 10);
        set_cfg(ht, $urandom_range(0, ht), $urandom_range(0, ht), $urandom_range(0, ht + 4),
                vt, $urandom_range(0, vt), $urandom_range(0, vt), $urandom_range(0, vt + 2),
                1'($urandom), 1'($urandom), $urandom_range(0, 3), 12'($urandom));
    endtask

    initial begin
        d_now = '0;
        bus.data_i = '0;
        bus.enable_i = 1'b1;
        set_cfg(10, 2, 3, 8, 6, 1, 2, 5, 1'b0, 1'b0, 0, 12'h5A3);
        reset = 1'b1;
        @(negedge clk);
        run(3);
        reset = 1'b0;
        run(200);                                   // tiny timing, external data
        set_cfg(10, 2, 3, 8, 6, 1, 2, 5, 1'b1, 1'b1, 0, 12'h5A3);
        run(150);                                   // active-high syncs
        set_cfg(80, 6, 8, 72, 5, 1, 1, 4, 1'b0, 1'b1, 1, 12'h000);
        run(900);                                   // 8 bars of 8
        set_cfg(80, 4, 5, 75, 5, 1, 1, 4, 1'b1, 1'b0, 1, 12'h000);
        run(900);                                   // width 70, wide white bar
        set_cfg(6, 1, 1, 5, 4, 1, 0, 3, 1'b0, 1'b0, 1, 12'h000);
        run(60);                                    // bar_w == 0
        set_cfg(48, 4, 4, 44, 40, 2, 2, 38, 1'b0, 1'b0, 2, 12'h000);
        run(2100);                                  // checkerboard
        set_cfg(20, 3, 2, 18, 6, 1, 1, 5, 1'b1, 1'b1, 3, 12'h6C9);
        run(150);                                   // solid
        run(37);
        set_cfg(30, 5, 4, 24, 8, 2, 1, 7, 1'b0, 1'b1, 0, 12'h6C9);
        run(400);                                   // mid-frame change
        run(23);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(300);                                   // reset mid-line
        bus.enable_i = 1'b0;
        run(100);
        bus.enable_i = 1'b1;
        run(300);                                   // enable restart
        for (int it = 0; it < 30; it++) begin
            int n;
            rand_cfg();
            n = $urandom_range(50, 600);
            for (int i = 0; i < n; i++) begin
                reset = ($urandom_range(0, 299) == 0);
                bus.enable_i = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, 79) == 0) begin
                    bus.mode_i    = 2'($urandom);
                    bus.hpol_i    = 1'($urandom);
                    bus.h_total_i = HW'($urandom_range(4, 60));
                    bus.v_act_end_i = VW'($urandom_range(0, 12));
                end
                tick();
            end
            reset = 1'b0;
            bus.enable_i = 1'b1;
        end
        run(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
